// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control unit: IF/ID/EX/MEM/WB sequencing with a memory-ready timeout and a retire counter.
// Define MCTRL_JR_EN to add jr decoding and the JumpReg output.
module multicycle_controller #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Option,
    input  logic [5:0]       Function,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCBranch,
    output logic             PCJump,
    output logic             IRWrite,
    output logic [1:0]       Regdst,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [1:0]       MemtoReg,
    output logic [2:0]       ALUOp,
    output logic             ALUSrc,
    output logic [1:0]       Sign,
    output logic             Regwrite,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             mem_fault,
`ifdef MCTRL_JR_EN
    output logic             JumpReg,
`endif
    output logic [CNT_W-1:0] insn_cnt
);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_ADDU, C_SUBU, C_ORI, C_LW, C_SW, C_BEQ, C_LUI, C_JAL, C_JR, C_ILL
    } cls_t;

    // Last wait-counter value before a missing mem_ready becomes a fault
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    cls_t             cls_q, cls_d;
    cls_t             dec_cls;
    logic [7:0]       wait_q, wait_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    always_comb begin
        dec_cls = C_ILL;
        case (Option)
            6'b000000: begin
                if (Function == 6'b100001)      dec_cls = C_ADDU;
                else if (Function == 6'b100011) dec_cls = C_SUBU;
`ifdef MCTRL_JR_EN
                else if (Function == 6'b001000) dec_cls = C_JR;
`endif
            end
            6'b001101: dec_cls = C_ORI;
            6'b100011: dec_cls = C_LW;
            6'b101011: dec_cls = C_SW;
            6'b000100: dec_cls = C_BEQ;
            6'b001111: dec_cls = C_LUI;
            6'b000011: dec_cls = C_JAL;
            default:   dec_cls = C_ILL;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        wait_d  = 8'd0;
        fault_d = fault_q;
        retire  = 1'b0;
        case (state_q)
            S_INIT: state_d = S_IF;
            S_IF: begin
                if (mem_ready) begin
                    state_d = S_ID;
                end else if (wait_q == TO_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_IF;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_ID: begin
                cls_d = dec_cls;
                case (dec_cls)
                    C_ILL:   state_d = S_IF;
                    C_JAL:   state_d = S_WB;
                    default: state_d = S_EX;
                endcase
            end
            S_EX: begin
                case (cls_q)
                    C_LW, C_SW: state_d = S_MEM;
                    C_BEQ, C_JR: begin
                        state_d = S_IF;
                        retire  = 1'b1;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (cls_q == C_SW) begin
                        state_d = S_IF;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == TO_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_IF;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                state_d = S_IF;
                retire  = 1'b1;
            end
            default: state_d = S_INIT;
        endcase
        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_INIT;
            cls_q   <= C_ILL;
            wait_q  <= 8'd0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore strobes from state and registered class; only IRWrite/PCWrite look at mem_ready
    always_comb begin
        PCWrite  = 1'b0;
        PCBranch = 1'b0;
        PCJump   = 1'b0;
        IRWrite  = 1'b0;
        Regdst   = 2'b00;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 2'b00;
        ALUOp    = 3'b000;
        ALUSrc   = 1'b0;
        Sign     = 2'b00;
        Regwrite = 1'b0;
        illegal  = 1'b0;
`ifdef MCTRL_JR_EN
        JumpReg  = 1'b0;
`endif
        case (state_q)
            S_IF: begin
                MemRead = 1'b1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_ID: illegal = (dec_cls == C_ILL);
            S_EX: begin
                case (cls_q)
                    C_SUBU: ALUOp = 3'b001;
                    C_ORI: begin
                        ALUOp  = 3'b010;
                        ALUSrc = 1'b1;
                    end
                    C_LUI: begin
                        ALUOp  = 3'b011;
                        ALUSrc = 1'b1;
                        Sign   = 2'b10;
                    end
                    C_LW, C_SW: begin
                        ALUSrc = 1'b1;
                        Sign   = 2'b01;
                    end
                    C_BEQ: begin
                        ALUOp    = 3'b001;
                        PCBranch = Zero;
                    end
`ifdef MCTRL_JR_EN
                    C_JR: begin
                        PCJump  = 1'b1;
                        JumpReg = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            S_MEM: begin
                MemRead  = (cls_q == C_LW);
                MemWrite = (cls_q == C_SW);
            end
            S_WB: begin
                Regwrite = 1'b1;
                case (cls_q)
                    C_ADDU, C_SUBU: Regdst = 2'b01;
                    C_LW:           MemtoReg = 2'b01;
                    C_JAL: begin
                        Regdst   = 2'b10;
                        MemtoReg = 2'b10;
                        PCJump   = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign state     = state_q;
    assign mem_fault = fault_q;
    assign insn_cnt  = cnt_q;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle MIPS control unit: the successor to the single-cycle `controller`. It decodes the same `Option`/`Function` fields, but sequences each instruction through fetch, decode, execute, memory and write-back states, and emits per-state datapath strobes. It waits on a memory ready handshake, bounded by a timeout, and counts retired instructions. It sits between the instruction register and the multi-cycle datapath of the P5 CPU.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum cycles to wait for `mem_ready` in IF/MEM before faulting (1..255).
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Option`  in  6  opcode field from the instruction register.
- `Function`  in  6  funct field from the instruction register.
- `Zero`  in  1  ALU equality flag, sampled in EX for `beq`.
- `mem_ready`  in  1  memory completion for the current IF or MEM access.
- `PCWrite`  out  1  load PC with PC+4.
- `PCBranch`  out  1  load PC with the branch target.
- `PCJump`  out  1  load PC with the jump target.
- `IRWrite`  out  1  load the instruction register.
- `Regdst`  out  2  00 rt, 01 rd, 10 $31.
- `MemRead`  out  1  memory read strobe.
- `MemWrite`  out  1  memory write strobe.
- `MemtoReg`  out  2  00 ALU result, 01 memory data, 10 PC+4.
- `ALUOp`  out  3  000 add, 001 sub, 010 or, 011 lui (imm<<16).
- `ALUSrc`  out  1  0 register, 1 extended immediate.
- `Sign`  out  2  00 zero-extend, 01 sign-extend, 10 upper.
- `Regwrite`  out  1  register file write enable.
- `state`  out  3  current state, for debug.
- `illegal`  out  1  one-cycle pulse on an undecodable instruction.
- `mem_fault`  out  1  sticky; set on a handshake timeout.
- `insn_cnt`  out  CNT_W  retired-instruction count.

## Operation
States:
- S_INIT=0, S_IF=1, S_ID=2, S_EX=3, S_MEM=4, S_WB=5.
- Reset enters S_INIT. S_INIT always goes to S_IF on the next edge.

S_IF:
- `MemRead`=1 for the whole state.
- On `mem_ready`: `IRWrite`=1 and `PCWrite`=1 in that same cycle, then go to S_ID.

S_ID:
- Decodes `Option`/`Function` into a registered class: ADDU (000000/100001), SUBU (000000/100011), ORI 001101, LW 100011, SW 101011, BEQ 000100, LUI 001111, JAL 000011.
- Later states use only the registered class, so `Option`/`Function` changes after S_ID are ignored.
- An unknown encoding pulses `illegal` and returns to S_IF without retiring.

Paths:
- ADDU/SUBU: ID→EX→WB. In EX, `ALUOp` is 000/001 and `ALUSrc`=0. In WB, `Regdst`=01 and `Regwrite`=1.
- ORI: ID→EX→WB. In EX, `ALUOp`=010, `ALUSrc`=1, `Sign`=00. In WB, `Regdst`=00 and `Regwrite`=1.
- LUI: as ORI, but `ALUOp`=011 and `Sign`=10.
- LW: ID→EX→MEM→WB. In EX, add with `Sign`=01. In MEM, `MemRead`=1 until `mem_ready`. In WB, `MemtoReg`=01 and `Regwrite`=1.
- SW: ID→EX→MEM→IF. In MEM, `MemWrite`=1 until `mem_ready`.
- BEQ: ID→EX→IF. In EX, `ALUOp`=001 and `PCBranch`=`Zero`.
- JAL: ID→WB→IF. In WB, `Regdst`=10, `MemtoReg`=10, `Regwrite`=1 and `PCJump`=1.

Outputs:
- All outputs are Moore-style, decoded from the state and the registered class. The exceptions are `IRWrite`/`PCWrite`, which are qualified by `mem_ready`.
- Every strobe not named for a state is 0.
- `insn_cnt` increments on the final edge of each legal instruction: the WB exit, the SW MEM exit, or the BEQ EX exit. It wraps modulo 2^CNT_W.

## Timing
Reset:
- While `reset`=0: state=S_INIT, all strobes 0, `Regdst`/`MemtoReg`/`ALUOp`/`Sign`=0, `illegal`=0, `mem_fault`=0, `insn_cnt`=0.
- Reset asserted mid-instruction aborts it immediately with no write or retire.

Latency with zero-wait memory (`mem_ready` high in the first cycle of IF/MEM):

| Instruction | Cycles |
|---|---|
| R-type, ORI, LUI | 4 |
| LW | 5 |
| SW | 4 |
| BEQ | 3 |
| JAL | 3 |

Each wait cycle adds 1.

Wait counter:
- Clears on entry to IF and on entry to MEM.
- Increments each cycle that `mem_ready`=0.
- If it reaches `TIMEOUT` with `mem_ready` still 0: set `mem_fault`, drop `MemRead`/`MemWrite`, go to S_IF without retiring.
- `mem_ready` asserted in the same cycle the count hits `TIMEOUT` is accepted and is not a fault.
- `mem_ready` outside IF/MEM is ignored.

## Configuration
Macro `MCTRL_JR_EN`:
- Defined: decodes `jr` (000000/001000) with path ID→EX→IF. In EX, `PCJump`=1 and `Regdst`=00, plus a `JumpReg` output of 1 (register-sourced target); 3 cycles; retires.
- Undefined: the `JumpReg` port is absent and 000000/001000 is illegal.

## Test plan
- Reset mid-LW MEM wait, then release → outputs all 0, `state`=0, `insn_cnt`=0, and the next fetch begins one cycle later in S_IF.
- Sequence addu, subu, ori, lw, sw, beq, lui, jal with `mem_ready`=1 → per-state strobes as specified, 4+4+4+5+4+3+4+3=31 cycles, `insn_cnt`=8.
- beq with `Zero`=1, then `Zero`=0 → `PCBranch` 1 for exactly one EX cycle in the first case, 0 in the second; both retire.
- LW with `mem_ready` low 3 cycles in MEM → `MemRead` held 4 cycles, WB follows, latency 8.
- `mem_ready` never asserted in IF with `TIMEOUT`=15 → `mem_fault`=1 after 15 cycles, re-enters S_IF, `insn_cnt` unchanged.
- Option=111111 → `illegal` pulses once in ID, S_IF is next, no `Regwrite`/`MemWrite`, count unchanged.
